// File: rtl/ysyx_23060332_wb_arb_pkg.sv
// rtl/ysyx_23060332_wb_arb_pkg.sv - shared widths, counter limit and arbiter pointer encoding
package ysyx_23060332_wb_arb_pkg;

    localparam int WB_ADDR_W  = 5;
    localparam int WB_DATA_W  = 32;
    localparam int WB_CNT_W   = 2;
    localparam int WB_CNT_MAX = (1 << WB_CNT_W) - 1;

    typedef enum logic {
        PTR_EXU = 1'b0,
        PTR_LSU = 1'b1
    } wb_ptr_e;

endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// rtl/ysyx_23060332_scoreboard.sv - per-register pending-write counters with busy lookups
module ysyx_23060332_scoreboard
    import ysyx_23060332_wb_arb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_valid_i,
    input  logic [ADDR_W-1:0] inc_addr_i,
    input  logic              dec_valid_i,
    input  logic [ADDR_W-1:0] dec_addr_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              full_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < NREG; i++) begin
            // Simultaneous inc and dec on one register cancel out.
            if (inc_valid_i && (inc_addr_i == ADDR_W'(i)) &&
                !(dec_valid_i && (dec_addr_i == ADDR_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_valid_i && (dec_addr_i == ADDR_W'(i)) &&
                         !(inc_valid_i && (inc_addr_i == ADDR_W'(i))) &&
                         (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy1_o = (raddr1_i != '0) && (cnt_q[raddr1_i] != '0);
    assign busy2_o = (raddr2_i != '0) && (cnt_q[raddr2_i] != '0);
    assign full_o  = (cnt_q[inc_addr_i] == {CNT_W{1'b1}});

endmodule

// File: rtl/ysyx_23060332_wb_arb.sv
// rtl/ysyx_23060332_wb_arb.sv - round-robin EXU/LSU writeback arbiter with RAW hazard scoreboard
module ysyx_23060332_wb_arb
    import ysyx_23060332_wb_arb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_waddr,
    output logic              issue_ready,
    input  logic              exu_valid,
    input  logic [ADDR_W-1:0] exu_waddr,
    input  logic [DATA_W-1:0] exu_wdata,
    output logic              exu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              stall,
    output logic              reg_wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    wb_ptr_e           ptr_q, ptr_d;
    logic              exu_gnt, lsu_gnt, xfer;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              issue_acc, busy1, busy2, full;

    // Readies stay low while reset is asserted so nothing can transfer.
    always_comb begin
        exu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (rst) begin
            if (exu_valid && lsu_valid) begin
                exu_gnt = (ptr_q == PTR_EXU);
                lsu_gnt = (ptr_q == PTR_LSU);
            end else begin
                exu_gnt = exu_valid;
                lsu_gnt = lsu_valid;
            end
        end
    end

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;
    assign xfer      = exu_gnt | lsu_gnt;
    assign gnt_addr  = lsu_gnt ? lsu_waddr : exu_waddr;
    assign gnt_data  = lsu_gnt ? lsu_wdata : exu_wdata;

    always_comb begin
        ptr_d   = ptr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (exu_gnt) begin
            ptr_d = PTR_LSU;
        end else if (lsu_gnt) begin
            ptr_d = PTR_EXU;
        end
        if (xfer) begin
            wen_d   = (gnt_addr != '0);
            waddr_d = gnt_addr;
            wdata_d = gnt_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= PTR_EXU;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign reg_wen = wen_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;

    assign issue_ready = rst && ((issue_waddr == '0) || !full);
    assign issue_acc   = issue_valid && issue_ready && (issue_waddr != '0);
    assign stall       = rst && (busy1 || busy2);

    ysyx_23060332_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .inc_valid_i (issue_acc),
        .inc_addr_i  (issue_waddr),
        .dec_valid_i (wen_q),
        .dec_addr_i  (waddr_q),
        .raddr1_i    (raddr1),
        .raddr2_i    (raddr2),
        .busy1_o     (busy1),
        .busy2_o     (busy2),
        .full_o      (full)
    );

endmodule

// File: tb/tb_ysyx_23060332_wb_arb.sv
// tb/tb_ysyx_23060332_wb_arb.sv - directed self-checking bench for the writeback arbiter
module tb_ysyx_23060332_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_waddr;
    logic        issue_ready;
    logic        exu_valid;
    logic [4:0]  exu_waddr;
    logic [31:0] exu_wdata;
    logic        exu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        stall;
    logic        reg_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_23060332_wb_arb dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_waddr (issue_waddr),
        .issue_ready (issue_ready),
        .exu_valid   (exu_valid),
        .exu_waddr   (exu_waddr),
        .exu_wdata   (exu_wdata),
        .exu_ready   (exu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_waddr   (lsu_waddr),
        .lsu_wdata   (lsu_wdata),
        .lsu_ready   (lsu_ready),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .stall       (stall),
        .reg_wen     (reg_wen),
        .waddr       (waddr),
        .wdata       (wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_waddr = '0;
        exu_valid = 1'b0; exu_waddr = '0; exu_wdata = '0;
        lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        exu_valid = 1'b1; lsu_valid = 1'b1; issue_valid = 1'b1; issue_waddr = 5'd3;
        #3;
        chk("rst_exu_ready", 32'(exu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_reg_wen", 32'(reg_wen), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();

        // Issue x5, EXU writes it, stall held until after the commit
        issue_valid = 1'b1; issue_waddr = 5'd5;
        #1 chk("x5_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0; raddr1 = 5'd5;
        #1 chk("x5_stall_pending", 32'(stall), 32'd1);
        exu_valid = 1'b1; exu_waddr = 5'd5; exu_wdata = 32'h1234;
        #1 chk("x5_exu_ready", 32'(exu_ready), 32'd1);
        tick();
        exu_valid = 1'b0;
        #1;
        chk("x5_reg_wen", 32'(reg_wen), 32'd1);
        chk("x5_waddr", 32'(waddr), 32'd5);
        chk("x5_wdata", wdata, 32'h1234);
        chk("x5_stall_commit_cycle", 32'(stall), 32'd1);
        tick();
        chk("x5_reg_wen_off", 32'(reg_wen), 32'd0);
        chk("x5_stall_released", 32'(stall), 32'd0);
        raddr1 = '0;

        // Contention from a fresh pointer: EXU, LSU, EXU, LSU
        pulse_reset();
        exu_valid = 1'b1; exu_waddr = 5'd1; exu_wdata = 32'hAAAA_0001;
        lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'hBBBB_0002;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_exu_ready_%0d", k), 32'(exu_ready), 32'((k % 2) == 0));
            chk($sformatf("rr_lsu_ready_%0d", k), 32'(lsu_ready), 32'((k % 2) == 1));
            tick();
            chk($sformatf("rr_reg_wen_%0d", k), 32'(reg_wen), 32'd1);
            chk($sformatf("rr_waddr_%0d", k), 32'(waddr), (k % 2) == 0 ? 32'd1 : 32'd2);
            chk($sformatf("rr_wdata_%0d", k), wdata, (k % 2) == 0 ? 32'hAAAA_0001 : 32'hBBBB_0002);
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        chk("rr_reg_wen_done", 32'(reg_wen), 32'd0);
        raddr1 = 5'd1; raddr2 = 5'd2;
        #1 chk("rr_no_underflow_stall", 32'(stall), 32'd0);
        raddr1 = '0; raddr2 = '0;

        // Fill x7 to the limit, then free one slot with a commit
        issue_valid = 1'b1; issue_waddr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("x7_issue_ready_%0d", k), 32'(issue_ready), 32'd1);
            tick();
        end
        #1 chk("x7_issue_full", 32'(issue_ready), 32'd0);
        tick();
        issue_valid = 1'b0;
        exu_valid = 1'b1; exu_waddr = 5'd7; exu_wdata = 32'h77;
        tick();
        exu_valid = 1'b0;
        issue_valid = 1'b1;
        #1 chk("x7_full_commit_cycle", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        tick();
        issue_valid = 1'b1;
        #1 chk("x7_ready_after_commit", 32'(issue_ready), 32'd1);
        issue_valid = 1'b0;
        raddr2 = 5'd7;
        #1 chk("x7_stall_pending", 32'(stall), 32'd1);
        raddr2 = '0;

        // Issue and commit of x9 on the same edge cancel
        issue_valid = 1'b1; issue_waddr = 5'd9;
        tick();
        issue_valid = 1'b0;
        exu_valid = 1'b1; exu_waddr = 5'd9; exu_wdata = 32'h99;
        tick();
        exu_valid = 1'b0;
        issue_valid = 1'b1; issue_waddr = 5'd9;
        #1 chk("x9_wen_and_issue", 32'(reg_wen & issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0; raddr2 = 5'd9;
        #1 chk("x9_stall_kept", 32'(stall), 32'd1);
        exu_valid = 1'b1;
        tick();
        exu_valid = 1'b0;
        tick();
        chk("x9_drained", 32'(stall), 32'd0);
        raddr2 = '0;

        // LSU write to x0 is accepted but never reaches the register file
        lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hFFFF_FFFF;
        #1 chk("x0_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("x0_reg_wen", 32'(reg_wen), 32'd0);
        issue_valid = 1'b1; issue_waddr = 5'd0;
        #1 chk("x0_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("x0_stall", 32'(stall), 32'd0);

        // Reset mid-flight: x7 still has 2 pending, output stage holds x4
        exu_valid = 1'b1; exu_waddr = 5'd4; exu_wdata = 32'h44;
        tick();
        exu_valid = 1'b0; raddr1 = 5'd7;
        #1 chk("mid_wen_before_rst", 32'(reg_wen), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_reg_wen", 32'(reg_wen), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rel_stall", 32'(stall), 32'd0);
        chk("mid_rel_reg_wen", 32'(reg_wen), 32'd0);
        tick();
        chk("mid_rel_reg_wen_next", 32'(reg_wen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
